// File: rtl/seven_capture.sv
// Monitor for a multiplexed 4-digit active-low seven-segment bus: debounces each
// anode dwell, decodes the glyph back to BCD and publishes a full frame with a strobe.
module seven_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stalled
);

  localparam int unsigned RUN_W = 8;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  // Registered bus sample and dwell tracking
  logic [3:0]       s_an;
  logic [7:0]       s_seg;
  logic [RUN_W-1:0] run;
  logic             armed;

  // Frame assembly state
  logic [3:0]       mask;
  logic [15:0]      stg_digits;
  logic [3:0]       stg_dp;
  logic [3:0]       stg_err;
  logic [TO_W-1:0]  to_cnt;

  logic             change_c;
  logic [3:0]       an_act_c;
  logic             one_hot_c;
  logic             cap_c;
  logic [1:0]       pos_c;
  logic [3:0]       nib_c;
  logic             err_c;
  logic             publish_c;
  logic             timeout_c;
  logic [3:0]       mask_next_c;

  // Capture qualification on the registered sample
  always_comb begin
    change_c  = ({an, seg} != {s_an, s_seg});
    an_act_c  = ~s_an;
    one_hot_c = (an_act_c != 4'd0) && ((an_act_c & (an_act_c - 4'd1)) == 4'd0);
    cap_c     = (run == RUN_MAX) && armed && one_hot_c;
    publish_c = (mask == 4'b1111);
    timeout_c = !cap_c && (to_cnt == (TO_MAX - TO_W'(1)));
  end

  // Active anode to position index; only meaningful when one_hot_c is set
  always_comb begin
    case (an_act_c)
      4'b0001: pos_c = 2'd0;
      4'b0010: pos_c = 2'd1;
      4'b0100: pos_c = 2'd2;
      default: pos_c = 2'd3;
    endcase
  end

  // Glyph decode, active-low g..a; dp is ignored here
  always_comb begin
    nib_c = 4'hF;
    err_c = 1'b0;
    case (s_seg[6:0])
      7'b1000000: nib_c = 4'd0;
      7'b1111001: nib_c = 4'd1;
      7'b0100100: nib_c = 4'd2;
      7'b0110000: nib_c = 4'd3;
      7'b0011001: nib_c = 4'd4;
      7'b0010010: nib_c = 4'd5;
      7'b0000010: nib_c = 4'd6;
      7'b1111000: nib_c = 4'd7;
      7'b0000000: nib_c = 4'd8;
      7'b0010000: nib_c = 4'd9;
      default: begin
        nib_c = 4'hF;
        err_c = 1'b1;
      end
    endcase
  end

  // A capture landing in the publish cycle goes into the freshly cleared mask
  always_comb begin
    mask_next_c = mask;
    if (publish_c || timeout_c) begin
      mask_next_c = 4'b0000;
    end
    if (cap_c) begin
      mask_next_c[pos_c] = 1'b1;
    end
  end

  // Input sampling, run length and one-capture-per-dwell arming
  always_ff @(posedge clk) begin
    if (rst) begin
      s_an  <= 4'hF;
      s_seg <= 8'hFF;
      run   <= '0;
      armed <= 1'b1;
    end else begin
      if (cap_c) begin
        armed <= 1'b0;
      end
      if (change_c) begin
        s_an  <= an;
        s_seg <= seg;
        run   <= RUN_W'(1);
        armed <= 1'b1;
      end else if (run != RUN_MAX) begin
        run <= run + RUN_W'(1);
      end
    end
  end

  // Staging, mask and frame publish
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_digits  <= 16'hFFFF;
      stg_dp      <= 4'h0;
      stg_err     <= 4'hF;
      mask        <= 4'h0;
      digits      <= 16'hFFFF;
      dp          <= 4'h0;
      digit_err   <= 4'hF;
      frame_valid <= 1'b0;
    end else begin
      if (cap_c) begin
        stg_digits[{pos_c, 2'b00} +: 4] <= nib_c;
        stg_dp[pos_c]                   <= ~s_seg[7];
        stg_err[pos_c]                  <= err_c;
      end
      mask        <= mask_next_c;
      frame_valid <= publish_c;
      if (publish_c) begin
        digits    <= stg_digits;
        dp        <= stg_dp;
        digit_err <= stg_err;
      end
    end
  end

  // Stall watchdog; counter saturates so the stall event fires once
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      stalled <= 1'b0;
    end else begin
      if (cap_c) begin
        to_cnt  <= '0;
        stalled <= 1'b0;
      end else begin
        if (to_cnt != TO_MAX) begin
          to_cnt <= to_cnt + TO_W'(1);
        end
        if (timeout_c) begin
          stalled <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_capture.sv
// Directed bench for seven_capture: two instances share the bus, one with a
// long watchdog (functional scenarios) and one with a 16-cycle watchdog.
module tb_seven_capture;

  localparam logic [3:0] P0 = 4'b1110;
  localparam logic [3:0] P1 = 4'b1101;
  localparam logic [3:0] P2 = 4'b1011;
  localparam logic [3:0] P3 = 4'b0111;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [7:0]  seg;

  logic [15:0] digits_a, digits_b;
  logic [3:0]  dp_a, dp_b, err_a, err_b;
  logic        fv_a, fv_b, stalled_a, stalled_b;

  int checks;
  int errors;
  int fv_cnt_a;
  int fv_cnt_b;
  logic [15:0] last_frame;
  logic [15:0] prev_frame;

  seven_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .digits(digits_a), .dp(dp_a), .digit_err(err_a),
    .frame_valid(fv_a), .stalled(stalled_a)
  );

  seven_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .digits(digits_b), .dp(dp_b), .digit_err(err_b),
    .frame_valid(fv_b), .stalled(stalled_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame pulse counters and frame log
  always @(posedge clk) begin
    if (fv_a) begin
      fv_cnt_a   <= fv_cnt_a + 1;
      prev_frame <= last_frame;
      last_frame <= digits_a;
    end
    if (fv_b) begin
      fv_cnt_b <= fv_cnt_b + 1;
    end
  end

  function automatic logic [7:0] gl(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b1000000;
      1: p = 7'b1111001;
      2: p = 7'b0100100;
      3: p = 7'b0110000;
      4: p = 7'b0011001;
      5: p = 7'b0010010;
      6: p = 7'b0000010;
      7: p = 7'b1111000;
      8: p = 7'b0000000;
      default: p = 7'b0010000;
    endcase
    return {1'b1, p};
  endfunction

  task automatic apply(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({digits_a, dp_a, err_a, fv_a, stalled_a} !== {16'hFFFF, 4'h0, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got digits=%h dp=%b err=%b fv=%b st=%b, want FFFF 0000 1111 0 0",
               digits_a, dp_a, err_a, fv_a, stalled_a);
    end
    checks++;
    if ({digits_b, dp_b, err_b, fv_b, stalled_b} !== {16'hFFFF, 4'h0, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got digits=%h dp=%b err=%b fv=%b st=%b, want FFFF 0000 1111 0 0",
               digits_b, dp_b, err_b, fv_b, stalled_b);
    end
  endtask

  task automatic test_scan();
    int base;
    int first;
    do_reset();
    base  = fv_cnt_a;
    first = 0;
    apply(P0, gl(1), 6);
    apply(P1, gl(2), 6);
    apply(P2, gl(3), 6);
    an  = P3;
    seg = gl(4);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (fv_a && first == 0) first = i;
      if (i == 5) begin
        checks++;
        if (digits_a !== 16'hFFFF) begin
          errors++;
          $display("FAIL scan_hold: digits=%h before publish, want FFFF", digits_a);
        end
      end
    end
    apply(4'hF, 8'hFF, 4);
    checks++;
    if (first != 6) begin
      errors++;
      $display("FAIL scan_latency: frame_valid at negedge %0d after apply, want 6", first);
    end
    checks++;
    if (fv_cnt_a - base != 1) begin
      errors++;
      $display("FAIL scan_count: %0d pulses, want 1", fv_cnt_a - base);
    end
    checks++;
    if ({digits_a, err_a, dp_a} !== {16'h4321, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL scan_frame: digits=%h err=%b dp=%b, want 4321 0000 0000", digits_a, err_a, dp_a);
    end
  endtask

  task automatic test_short_dwell();
    int base;
    int first;
    do_reset();
    base  = fv_cnt_a;
    first = 0;
    apply(P0, gl(0), 3);
    apply(P1, gl(1), 6);
    apply(P2, gl(2), 6);
    apply(P3, gl(3), 6);
    apply(4'hF, 8'hFF, 6);
    checks++;
    if (fv_cnt_a != base || digits_a !== 16'hFFFF) begin
      errors++;
      $display("FAIL short_dwell_nocap: pulses=%0d digits=%h, want 0 FFFF", fv_cnt_a - base, digits_a);
    end
    an  = P0;
    seg = gl(0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (fv_a && first == 0) first = i;
      if (i == 4) begin
        an  = 4'hF;
        seg = 8'hFF;
      end
    end
    checks++;
    if (first != 6) begin
      errors++;
      $display("FAIL exact_dwell_latency: frame_valid at negedge %0d, want 6", first);
    end
    checks++;
    if (digits_a !== 16'h3210 || fv_cnt_a - base != 1) begin
      errors++;
      $display("FAIL exact_dwell_frame: digits=%h pulses=%0d, want 3210 1", digits_a, fv_cnt_a - base);
    end
  endtask

  task automatic test_multi_blank();
    int base;
    do_reset();
    base = fv_cnt_a;
    apply(P0, gl(5), 6);
    apply(P1, gl(6), 6);
    apply(P2, gl(7), 6);
    apply(4'b1100, gl(8), 20);
    apply(4'b1111, gl(8), 20);
    checks++;
    if (fv_cnt_a != base) begin
      errors++;
      $display("FAIL multi_blank_nofv: %0d pulses, want 0", fv_cnt_a - base);
    end
    apply(P3, gl(9), 6);
    apply(4'hF, 8'hFF, 4);
    checks++;
    if (fv_cnt_a - base != 1 || digits_a !== 16'h9765 || err_a !== 4'h0) begin
      errors++;
      $display("FAIL multi_blank_frame: pulses=%0d digits=%h err=%b, want 1 9765 0000",
               fv_cnt_a - base, digits_a, err_a);
    end
  endtask

  task automatic test_bad_glyph();
    int base;
    do_reset();
    base = fv_cnt_a;
    apply(P0, gl(1), 6);
    apply(P1, gl(2), 6);
    apply(P2, 8'b0111_1111, 6);
    apply(P3, gl(4), 6);
    apply(4'hF, 8'hFF, 4);
    checks++;
    if (fv_cnt_a - base != 1 || digits_a !== 16'h4F21) begin
      errors++;
      $display("FAIL bad_glyph_digits: pulses=%0d digits=%h, want 1 4F21", fv_cnt_a - base, digits_a);
    end
    checks++;
    if (err_a !== 4'b0100 || dp_a !== 4'b0100) begin
      errors++;
      $display("FAIL bad_glyph_flags: err=%b dp=%b, want 0100 0100", err_a, dp_a);
    end
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    base = fv_cnt_b;
    apply(P0, gl(1), 6);
    an  = P1;
    seg = gl(2);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i == 6) begin
        an  = 4'hF;
        seg = 8'hFF;
      end
      if (i == 20) begin
        checks++;
        if (stalled_b !== 1'b0) begin
          errors++;
          $display("FAIL stall_early: stalled=%b at 15 cycles after capture, want 0", stalled_b);
        end
      end
      if (i == 21) begin
        checks++;
        if (stalled_b !== 1'b1) begin
          errors++;
          $display("FAIL stall_set: stalled=%b at 16 cycles after capture, want 1", stalled_b);
        end
        checks++;
        if (stalled_a !== 1'b0) begin
          errors++;
          $display("FAIL stall_long: long-timeout stalled=%b, want 0", stalled_a);
        end
      end
    end
    apply(P2, gl(3), 6);
    checks++;
    if (stalled_b !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear: stalled=%b after capture, want 0", stalled_b);
    end
    apply(P3, gl(4), 6);
    apply(4'hF, 8'hFF, 4);
    checks++;
    if (fv_cnt_b != base) begin
      errors++;
      $display("FAIL stall_mask_cleared: %0d pulses, want 0", fv_cnt_b - base);
    end
    apply(P0, gl(5), 6);
    apply(P1, gl(6), 6);
    apply(4'hF, 8'hFF, 4);
    checks++;
    if (fv_cnt_b - base != 1 || digits_b !== 16'h4365 || stalled_b !== 1'b0) begin
      errors++;
      $display("FAIL stall_rescan: pulses=%0d digits=%h st=%b, want 1 4365 0",
               fv_cnt_b - base, digits_b, stalled_b);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = fv_cnt_a;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] a;
      case (i % 4)
        0: a = P0;
        1: a = P1;
        2: a = P2;
        default: a = P3;
      endcase
      apply(a, gl(i + 1), 4);
    end
    apply(4'hF, 8'hFF, 6);
    checks++;
    if (fv_cnt_a - base != 2) begin
      errors++;
      $display("FAIL b2b_count: %0d pulses, want 2", fv_cnt_a - base);
    end
    checks++;
    if (prev_frame !== 16'h4321 || last_frame !== 16'h8765) begin
      errors++;
      $display("FAIL b2b_frames: first=%h second=%h, want 4321 8765", prev_frame, last_frame);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    base = fv_cnt_a;
    apply(P0, gl(1), 6);
    apply(P1, gl(2), 6);
    apply(P2, gl(3), 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply(P3, gl(4), 6);
    apply(4'hF, 8'hFF, 10);
    checks++;
    if (fv_cnt_a != base) begin
      errors++;
      $display("FAIL mid_reset_nofv: %0d pulses, want 0", fv_cnt_a - base);
    end
    checks++;
    if ({digits_a, dp_a, err_a, fv_a, stalled_a} !== {16'hFFFF, 4'h0, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_outputs: digits=%h dp=%b err=%b fv=%b st=%b, want FFFF 0000 1111 0 0",
               digits_a, dp_a, err_a, fv_a, stalled_a);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    fv_cnt_a   = 0;
    fv_cnt_b   = 0;
    last_frame = 16'h0;
    prev_frame = 16'h0;
    rst        = 1'b1;
    an         = 4'hF;
    seg        = 8'hFF;
    test_reset();
    test_scan();
    test_short_dwell();
    test_multi_blank();
    test_bad_glyph();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_capture.md
Name: seven_capture

Overview:
- Receive-side counterpart of the seven-segment encoder: watches a multiplexed 4-digit active-low display bus (anodes plus segments) and recovers the BCD digit shown at each position.
- Debounces each anode dwell, decodes the segment pattern back to a digit, and collects all four positions in staging registers.
- Publishes a full 16-bit frame with a one-cycle strobe once all four positions are collected.
- Used as an on-chip monitor and scoreboard for the score/timer display path, and for self-checking benches.

Parameters:
- STABLE_CYCLES, default 4: consecutive identical registered samples required before a capture; legal range 2..255.
- TIMEOUT_CYCLES, default 1000000: cycles without any capture before the block declares the bus stalled; legal range ≥16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- an  in  4  anode selects, active-low; bit i = digit position i
- seg  in  8  segments, active-low; seg[7]=dp, seg[6:0]=g..a
- digits  out  16  recovered frame; nibble i = position i
- dp  out  4  decimal-point state per position, 1 = lit
- digit_err  out  4  per-position flag, 1 = pattern was not a legal 0-9 glyph
- frame_valid  out  1  one-cycle pulse when digits/dp/digit_err update
- stalled  out  1  level; no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (sync, active-high, wins over all other activity) clears everything:
  - outputs: digits=16'hFFFF, dp=0, digit_err=4'hF, frame_valid=0, stalled=0
  - internal state: staging, capture mask, run counter, armed flag=1, timeout counter.
- Input stage:
  - {an,seg} is registered once into sample s.
  - Run length R counts consecutive cycles s is unchanged; it restarts at 1 on any change and saturates at STABLE_CYCLES.
  - Any change in s re-arms the capture.
- Capture conditions, all true in the same cycle:
  - R==STABLE_CYCLES
  - armed=1
  - s.an has exactly one zero bit
- Capture actions, on the next edge:
  - staging nibble[i] written; staging dp[i]=~seg[7]; staging err[i] written
  - mask[i] set; armed cleared, so only one capture per dwell.
- Timing: a pattern applied before edge k is captured at edge k+STABLE_CYCLES.
- No capture occurs when:
  - an==4'b1111 (blank), or
  - more than one anode is active.
  - In either case R still runs.
- Decode (seg[6:0], active-low) → nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - Any other pattern, including all-off 1111111: nibble=4'hF, err=1.
  - A legal glyph gives err=0.
  - dp never affects the decode.
- Re-capture of a position whose mask bit is already set overwrites its staging entries; the mask is unchanged.
- Frame publish, triggered when mask==4'b1111 after an edge:
  - On the next edge, digits/dp/digit_err load from staging, frame_valid=1 for exactly one cycle, and mask clears.
  - A capture arriving in that same cycle is accepted into the freshly cleared mask; it is not lost.
- Outputs change only at frame publish (or reset). They hold between frames.
- Timeout:
  - The counter increments every cycle and clears on any capture.
  - On reaching TIMEOUT_CYCLES: stalled=1 and mask clears; staging contents are kept but must be recollected.
  - stalled drops on the edge after the next capture.
- Mid-frame reset: the partial mask is discarded, and no frame_valid is issued for it.

Test Plan:
- Scan positions 0..3 with glyphs for 1,2,3,4 (an=1110,1101,1011,0111), each held 6 cycles, STABLE_CYCLES=4 → exactly one frame_valid pulse, 5 cycles after the position-3 pattern is applied; digits=16'h4321, digit_err=0, dp=0.
- Hold position 0 with 1000000 for only 3 cycles, then change → no capture for that dwell. Same pattern held 4 cycles → captured at edge k+4.
- an=1100 with a valid glyph held 20 cycles, and an=1111 held 20 cycles → mask unchanged, no frame_valid.
- Position 2 shows seg=8'b0_1111111, others show legal glyphs → digits[11:8]=F, digit_err=4'b0100, dp=4'b0100.
- Stop scanning after two positions captured (TIMEOUT_CYCLES=16) → stalled=1 at cycle 16 after the last capture. A full rescan then yields one frame_valid and stalled=0.
- Assert rst for 1 cycle after 3 of 4 positions captured, then scan only position 3 → no frame_valid; outputs remain at reset values.
